inv_cipher_ctrl: RTL and testbench

INV_CIPHER_CTRL -- requirements
Module: inv_cipher_ctrl

---
 rtl/inv_cipher_ctrl.sv | 130 +++++++++++++
 tb/tb_inv_cipher_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_cipher_ctrl.sv
// inv_cipher_ctrl: sequences an iterative AES-128 inverse cipher over a shared round datapath.
// Optional feature: define INV_CIPHER_ABORT_EN to add the abort input.
//
// state | meaning
// IDLE  | ready for start; outputs parked at zero
// FETCH | key_rd strobe for round key[round]
// EXEC  | key_data valid; datapath result loaded into the state register
// DONE  | plaintext presented until ack
module inv_cipher_ctrl (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           start,
    input  logic [0:127]   cipher_in,
    output logic           ready,
    output logic           key_rd,
    output logic [3:0]     key_addr,
    input  logic [0:127]   key_data,
    output logic [0:127]   dp_text,
    output logic [0:127]   dp_key,
    output logic [1:0]     dp_mode,
    input  logic [0:127]   dp_result,
    output logic [0:127]   plain_out,
    output logic           done,
`ifdef INV_CIPHER_ABORT_EN
    input  logic           abort,
`endif
    input  logic           ack
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [1:0] MODE_FULL  = 2'd0;
    localparam logic [1:0] MODE_NOMIX = 2'd1;
    localparam logic [1:0] MODE_ARK   = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [0:127] text_q, text_d;
    logic         abort_hit;

`ifdef INV_CIPHER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        text_d  = text_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    round_d = LAST_ROUND;
                    text_d  = cipher_in;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                text_d = dp_result;
                // The round counter only counts down from 10 and stops at 0.
                if (round_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q - 4'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    text_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 4'd0;
                text_d  = '0;
            end
        endcase
        // Abort beats ack and drops any partial result.
        if (abort_hit && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
            text_d  = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
            text_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            text_q  <= text_d;
        end
    end

    always_comb begin
        dp_mode = MODE_FULL;
        if (state_q == ST_EXEC) begin
            if (round_q == LAST_ROUND) begin
                dp_mode = MODE_NOMIX;
            end else if (round_q == 4'd0) begin
                dp_mode = MODE_ARK;
            end else begin
                dp_mode = MODE_FULL;
            end
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign key_rd    = (state_q == ST_FETCH);
    assign key_addr  = ((state_q == ST_FETCH) || (state_q == ST_EXEC)) ? round_q : 4'd0;
    assign dp_text   = text_q;
    assign dp_key    = key_data;
    assign done      = (state_q == ST_DONE);
    assign plain_out = (state_q == ST_DONE) ? text_q : '0;

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Testbench for inv_cipher_ctrl: behavioural AES key store and round datapath around the DUT,
// forward-AES reference model feeding a scoreboard, and a monitor that checks outputs.
module tb_inv_cipher_ctrl;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic           start = 1'b0;
    logic           ack = 1'b0;
    logic [0:127]   cipher_in = '0;
    logic           ready;
    logic           key_rd;
    logic [3:0]     key_addr;
    logic [0:127]   key_data = '0;
    logic [0:127]   dp_text;
    logic [0:127]   dp_key;
    logic [1:0]     dp_mode;
    logic [0:127]   dp_result;
    logic [0:127]   plain_out;
    logic           done;
`ifdef INV_CIPHER_ABORT_EN
    logic           abort = 1'b0;
`endif

    always #5 Clk = ~Clk;

    inv_cipher_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .cipher_in (cipher_in),
        .ready     (ready),
        .key_rd    (key_rd),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .dp_text   (dp_text),
        .dp_key    (dp_key),
        .dp_mode   (dp_mode),
        .dp_result (dp_result),
        .plain_out (plain_out),
        .done      (done),
`ifdef INV_CIPHER_ABORT_EN
        .abort     (abort),
`endif
        .ack       (ack)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [0:127] rk [11];

    typedef struct {
        logic [0:127] plain;
        int           acc;
    } exp_t;
    exp_t exp_q[$];

    int           kidx = 0;
    bit           exec_pend = 0;
    bit           done_prev = 0;
    logic [0:127] held_plain = '0;

    localparam logic [0:127] FIPS_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] FIPS_CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] FIPS_PLAIN  = 128'h00112233445566778899aabbccddeeff;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s, xb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = xb;
        end
    endtask

    function automatic logic [0:127] sub_bytes(input logic [0:127] s, input bit inv);
        logic [0:127] o;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = inv ? isbox[s[8*i +: 8]] : sbox[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [0:127] shift_rows(input logic [0:127] s, input bit inv);
        logic [0:127] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*src) +: 8];
            end
        return o;
    endfunction

    function automatic logic [0:127] mix_cols(input logic [0:127] s, input bit inv);
        logic [0:127] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
            if (!inv) begin
                o[32*c    +: 8] = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
                o[32*c+8  +: 8] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
                o[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
                o[32*c+24 +: 8] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
            end else begin
                o[32*c    +: 8] = gmul(a0,14) ^ gmul(a1,11) ^ gmul(a2,13) ^ gmul(a3,9);
                o[32*c+8  +: 8] = gmul(a0,9)  ^ gmul(a1,14) ^ gmul(a2,11) ^ gmul(a3,13);
                o[32*c+16 +: 8] = gmul(a0,13) ^ gmul(a1,9)  ^ gmul(a2,14) ^ gmul(a3,11);
                o[32*c+24 +: 8] = gmul(a0,11) ^ gmul(a1,13) ^ gmul(a2,9)  ^ gmul(a3,14);
            end
        end
        return o;
    endfunction

    task automatic expand_key(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Reference: forward AES-128, so the bench knows the plaintext a ciphertext must decrypt to.
    function automatic logic [0:127] aes_encrypt(input logic [0:127] p);
        logic [0:127] s;
        s = p ^ rk[0];
        for (int r = 1; r < 10; r++)
            s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[10];
    endfunction

    function automatic logic [0:127] dp_fn(input logic [0:127] t, input logic [0:127] k,
                                           input logic [1:0] m);
        logic [0:127] x;
        x = t ^ k;
        case (m)
            2'd0:    return sub_bytes(shift_rows(mix_cols(x, 1'b1), 1'b1), 1'b1);
            2'd1:    return sub_bytes(shift_rows(x, 1'b1), 1'b1);
            default: return x;
        endcase
    endfunction

    // ---------------- environment: key store and datapath ----------------
    assign dp_result = dp_fn(dp_text, dp_key, dp_mode);

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (key_rd) key_data <= (key_addr <= 4'd10) ? rk[key_addr] : '0;
    end

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        if (!Reset_n) begin
            exec_pend = 0;
            done_prev = 0;
        end else begin
            if (exec_pend) begin
                chk("dp_mode", 128'(dp_mode), (kidx == 0) ? 128'(1) : (kidx == 10) ? 128'(2) : 128'(0));
                if (kidx <= 10) chk("dp_key", dp_key, rk[10 - kidx]);
                kidx++;
                exec_pend = 0;
            end
            if (key_rd) begin
                chk("key_addr", 128'(key_addr), 128'(10 - kidx));
                exec_pend = 1;
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 plain %h expected no result", plain_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("plain_out", plain_out, e.plain);
                    chk("latency", 128'(cyc - e.acc), 128'(22));
                end
                held_plain = plain_out;
            end else if (done && done_prev) begin
                chk("plain_stable", plain_out, held_plain);
            end
            done_prev = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs();
        chk("rst_ready",    128'(ready),    128'(1));
        chk("rst_done",     128'(done),     128'(0));
        chk("rst_key_rd",   128'(key_rd),   128'(0));
        chk("rst_key_addr", 128'(key_addr), 128'(0));
        chk("rst_dp_mode",  128'(dp_mode),  128'(0));
        chk("rst_plain",    plain_out,      128'(0));
        chk("rst_state",    dp_text,        128'(0));
    endtask

    task automatic issue(input logic [0:127] c, input logic [0:127] p);
        exp_t e;
        int   i;
        i = 0;
        while (!ready && i < 50) begin
            @(negedge Clk);
            i++;
        end
        if (!ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within 50 cycles");
        end
        cipher_in = c;
        start     = 1'b1;
        e.plain   = p;
        e.acc     = cyc + 1;
        exp_q.push_back(e);
        kidx = 0;
        @(negedge Clk);
        start     = 1'b0;
        cipher_in = {$urandom, $urandom, $urandom, $urandom};
        chk("busy_ready", 128'(ready), 128'(0));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (done) return;
            @(negedge Clk);
        end
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout: got done=0 expected 1 within 60 cycles");
    endtask

    task automatic finish_ack(input int hold, input bit with_start);
        repeat (hold) @(negedge Clk);
        chk("done_held", 128'(done), 128'(1));
        ack       = 1'b1;
        start     = with_start;
        cipher_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge Clk);
        chk("ack_ready", 128'(ready), 128'(1));
        chk("ack_done",  128'(done),  128'(0));
        ack   = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [0:127] p;
        init_sbox();
        expand_key(FIPS_KEY);
        repeat (3) @(negedge Clk);
        check_reset_outputs();
        Reset_n = 1'b1;
        @(negedge Clk);

        // FIPS-197 C.1 with five cycles of backpressure
        issue(FIPS_CIPHER, FIPS_PLAIN);
        wait_done();
        finish_ack(5, 1'b0);

        // start during EXEC is ignored; start alongside ack in DONE is ignored too
        issue(FIPS_CIPHER, FIPS_PLAIN);
        @(negedge Clk);
        start     = 1'b1;
        cipher_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge Clk);
        start = 1'b0;
        wait_done();
        finish_ack(0, 1'b1);

        // reset partway through an operation
        issue(FIPS_CIPHER, FIPS_PLAIN);
        repeat (8) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        @(negedge Clk);
        issue(FIPS_CIPHER, FIPS_PLAIN);
        wait_done();
        finish_ack(1, 1'b0);

`ifdef INV_CIPHER_ABORT_EN
        issue(FIPS_CIPHER, FIPS_PLAIN);
        repeat (11) @(negedge Clk);
        abort = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        abort = 1'b0;
        chk("abort_ready",  128'(ready),  128'(1));
        chk("abort_done",   128'(done),   128'(0));
        chk("abort_key_rd", 128'(key_rd), 128'(0));
        chk("abort_state",  dp_text,      128'(0));
        repeat (30) @(negedge Clk);
        abort = 1'b1;
        issue(FIPS_CIPHER, FIPS_PLAIN);
        abort = 1'b0;
        wait_done();
        finish_ack(2, 1'b0);
`endif

        // random keys and plaintexts, stray ack pulses mid-operation
        for (int n = 0; n < 6; n++) begin
            expand_key({$urandom, $urandom, $urandom, $urandom});
            p = {$urandom, $urandom, $urandom, $urandom};
            issue(aes_encrypt(p), p);
            if (n % 2 == 1) begin
                repeat (3) @(negedge Clk);
                ack = 1'b1;
                @(negedge Clk);
                ack = 1'b0;
            end
            wait_done();
            finish_ack($urandom_range(0, 5), 1'(n % 2));
        end

        repeat (5) @(negedge Clk);
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
